// File: rtl/reorder_buffer_pkg.sv
// Shared ROB widths, entry type codes and the per-entry record.
package reorder_buffer_pkg;
  localparam int ROB_SZ_C   = 16;
  localparam int ROB_ID_WID = 4;
  localparam int REG_ID_WID = 5;
  localparam int DATA_WID   = 32;

  typedef enum logic [1:0] {
    ROB_TYPE_REG = 2'd0,
    ROB_TYPE_BR  = 2'd1,
    ROB_TYPE_ST  = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    rob_type_e             rtype;
    logic [REG_ID_WID-1:0] rd;
    logic [DATA_WID-1:0]   data;
    logic [DATA_WID-1:0]   pc;
    logic [DATA_WID-1:0]   jump_addr;
    logic                  pred_taken;
    logic                  taken;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_logic.sv
// Head-entry evaluation: decides retire, commit, store and rollback.
module rob_retire_logic
  import reorder_buffer_pkg::*;
(
  input  logic        head_valid,
  input  rob_entry_t  head,
  output logic        retire,
  output logic        commit,
  output logic        store,
  output logic        rollback,
  output logic [31:0] rollback_pc
);
  always_comb begin
    retire      = 1'b0;
    commit      = 1'b0;
    store       = 1'b0;
    rollback    = 1'b0;
    rollback_pc = '0;
    if (head_valid && head.busy && head.ready) begin
      retire = 1'b1;
      case (head.rtype)
        ROB_TYPE_REG: commit = (head.rd != '0);
        ROB_TYPE_ST:  store = 1'b1;
        ROB_TYPE_BR: begin
          if (head.taken != head.pred_taken) begin
            rollback    = 1'b1;
            rollback_pc = head.taken ? head.jump_addr
                                     : head.pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with CDB capture and operand forwarding.
// Optional perf counters behind ROB_PERF_CNT_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SZ   = 16,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic [31:0]         issue_pc,
  input  logic [31:0]         issue_jump_addr,
  input  logic                issue_pred_taken,
  output logic [ROB_ID_W-1:0] issue_rob_id,
  output logic                rob_full,
  input  logic                wb_valid,
  input  logic [ROB_ID_W-1:0] wb_rob_id,
  input  logic [31:0]         wb_data,
  input  logic                wb_taken,
  input  logic [ROB_ID_W-1:0] query_id1,
  input  logic [ROB_ID_W-1:0] query_id2,
  output logic                query_ready1,
  output logic                query_ready2,
  output logic [31:0]         query_data1,
  output logic [31:0]         query_data2,
  output logic                is_commit,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_data,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                store_commit,
  output logic [ROB_ID_W-1:0] store_rob_id,
  output logic                rollback,
  output logic [31:0]         rollback_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_commit_cnt,
  output logic [31:0]         perf_rollback_cnt
`endif
);
  rob_entry_t          rob [ROB_SZ];
  logic [ROB_ID_W-1:0] head, tail;
  logic [ROB_ID_W:0]   count, count_nx;
  logic                acc;
  logic                ret, r_commit, r_store, r_rb;
  logic [31:0]         r_pc;

  assign rob_full     = (count == (ROB_ID_W+1)'(ROB_SZ));
  assign issue_rob_id = tail;
  assign acc          = issue_valid && !rob_full;

  assign query_ready1 = rob[query_id1].busy && rob[query_id1].ready;
  assign query_ready2 = rob[query_id2].busy && rob[query_id2].ready;
  assign query_data1  = query_ready1 ? rob[query_id1].data : '0;
  assign query_data2  = query_ready2 ? rob[query_id2].data : '0;

  rob_retire_logic u_retire (
    .head_valid  (count != '0),
    .head        (rob[head]),
    .retire      (ret),
    .commit      (r_commit),
    .store       (r_store),
    .rollback    (r_rb),
    .rollback_pc (r_pc)
  );

  always_comb begin
    count_nx = count;
    case ({acc, ret})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SZ; i++) rob[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      is_commit     <= 1'b0;
      commit_rd     <= '0;
      commit_data   <= '0;
      commit_rob_id <= '0;
      store_commit  <= 1'b0;
      store_rob_id  <= '0;
      rollback      <= 1'b0;
      rollback_pc   <= '0;
`ifdef ROB_PERF_CNT_EN
      perf_commit_cnt   <= '0;
      perf_rollback_cnt <= '0;
`endif
    end else if (rdy) begin
      is_commit    <= r_commit;
      store_commit <= r_store;
      rollback     <= r_rb;
      if (r_commit) begin
        commit_rd     <= rob[head].rd;
        commit_data   <= rob[head].data;
        commit_rob_id <= head;
      end
      if (r_store) store_rob_id <= head;
      if (r_rb) rollback_pc <= r_pc;
`ifdef ROB_PERF_CNT_EN
      if (ret) perf_commit_cnt <= perf_commit_cnt + 32'd1;
      if (r_rb) perf_rollback_cnt <= perf_rollback_cnt + 32'd1;
`endif
      if (r_rb) begin
        // mispredict: younger work is squashed, same-cycle inputs dropped
        for (int i = 0; i < ROB_SZ; i++) rob[i].busy <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (acc) begin
          rob[tail].busy       <= 1'b1;
          rob[tail].ready      <= 1'b0;
          rob[tail].rtype      <= rob_type_e'(issue_type);
          rob[tail].rd         <= issue_rd;
          rob[tail].pc         <= issue_pc;
          rob[tail].jump_addr  <= issue_jump_addr;
          rob[tail].pred_taken <= issue_pred_taken;
          tail                 <= tail + 1'b1;
        end
        if (wb_valid && rob[wb_rob_id].busy) begin
          rob[wb_rob_id].ready <= 1'b1;
          rob[wb_rob_id].data  <= wb_data;
          rob[wb_rob_id].taken <= wb_taken;
        end
        if (ret) begin
          rob[head].busy <= 1'b0;
          head           <= head + 1'b1;
        end
        count <= count_nx;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed table plus randomized run against a program-order queue model.
module tb_reorder_buffer;
  logic        clk = 0, rst = 1, rdy = 1;
  logic        issue_valid = 0;
  logic [1:0]  issue_type = 0;
  logic [4:0]  issue_rd = 0;
  logic [31:0] issue_pc = 0, issue_jump_addr = 0;
  logic        issue_pred_taken = 0;
  logic [3:0]  issue_rob_id;
  logic        rob_full;
  logic        wb_valid = 0;
  logic [3:0]  wb_rob_id = 0;
  logic [31:0] wb_data = 0;
  logic        wb_taken = 0;
  logic [3:0]  query_id1 = 0, query_id2 = 0;
  logic        query_ready1, query_ready2;
  logic [31:0] query_data1, query_data2;
  logic        is_commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [3:0]  commit_rob_id;
  logic        store_commit;
  logic [3:0]  store_rob_id;
  logic        rollback;
  logic [31:0] rollback_pc;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt, perf_rollback_cnt;
`endif

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_jump_addr(issue_jump_addr),
    .issue_pred_taken(issue_pred_taken),
    .issue_rob_id(issue_rob_id), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_data(wb_data), .wb_taken(wb_taken),
    .query_id1(query_id1), .query_id2(query_id2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_data1(query_data1), .query_data2(query_data2),
    .is_commit(is_commit), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_rob_id(commit_rob_id),
    .store_commit(store_commit), .store_rob_id(store_rob_id),
    .rollback(rollback), .rollback_pc(rollback_pc)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commit_cnt(perf_commit_cnt),
    .perf_rollback_cnt(perf_rollback_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // program-order model: entries in the queue are exactly the live ones
  typedef struct {
    int          id;
    int          typ;
    int          rd;
    logic [31:0] pc, ja, data;
    bit          pred, rdy, tkn;
  } ment_t;
  ment_t mq[$];
  int    m_tail = 0;

  function automatic void mquery(int id, output bit r, output logic [31:0] d);
    r = 0; d = 0;
    foreach (mq[i]) if (mq[i].id == id && mq[i].rdy) begin r = 1; d = mq[i].data; end
  endfunction

  task automatic step();
    bit er = 0, ec = 0, es = 0, eb = 0, acc, qr;
    int eid = 0, erd = 0;
    logic [31:0] ed = 0, epc = 0, qd;
    #1;
    chk("issue_rob_id", issue_rob_id, m_tail);
    chk("rob_full", rob_full, mq.size() == 16);
    mquery(query_id1, qr, qd);
    chk("query_ready1", query_ready1, qr);
    chk("query_data1", query_data1, qd);
    mquery(query_id2, qr, qd);
    chk("query_ready2", query_ready2, qr);
    chk("query_data2", query_data2, qd);
    if (mq.size() > 0 && mq[0].rdy) begin
      er = 1; eid = mq[0].id; erd = mq[0].rd; ed = mq[0].data;
      if (mq[0].typ == 0 && mq[0].rd != 0) ec = 1;
      if (mq[0].typ == 2) es = 1;
      if (mq[0].typ == 1 && mq[0].tkn != mq[0].pred) begin
        eb = 1;
        epc = mq[0].tkn ? mq[0].ja : mq[0].pc + 4;
      end
    end
    acc = issue_valid && mq.size() < 16;
    @(posedge clk); #1;
    if (eb) begin
      mq.delete(); m_tail = 0;
    end else begin
      if (wb_valid)
        foreach (mq[i]) if (mq[i].id == int'(wb_rob_id)) begin
          mq[i].rdy = 1; mq[i].data = wb_data; mq[i].tkn = wb_taken;
        end
      if (er) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{m_tail, int'(issue_type), int'(issue_rd),
                       issue_pc, issue_jump_addr, 32'd0,
                       issue_pred_taken, 1'b0, 1'b0});
        m_tail = (m_tail + 1) % 16;
      end
    end
    chk("is_commit", is_commit, ec);
    if (ec) begin
      chk("commit_rd", commit_rd, erd);
      chk("commit_data", commit_data, ed);
      chk("commit_rob_id", commit_rob_id, eid);
    end
    chk("store_commit", store_commit, es);
    if (es) chk("store_rob_id", store_rob_id, eid);
    chk("rollback", rollback, eb);
    if (eb) chk("rollback_pc", rollback_pc, epc);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mq.delete(); m_tail = 0;
  endtask

  task automatic idle_in();
    issue_valid = 0; wb_valid = 0;
  endtask

  typedef struct {
    bit iv; logic [1:0] ty; logic [4:0] rd; logic [31:0] pc, ja; bit pr;
    bit wv; logic [3:0] wid; logic [31:0] wd; bit wt;
    bit ec; logic [4:0] erd; logic [31:0] ed; logic [3:0] eid;
    bit es; logic [3:0] esid; bit eb; logic [31:0] epc;
  } vec_t;

  function automatic vec_t N();
    vec_t v;
    v = '{0,0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    return v;
  endfunction
  function automatic vec_t I(int ty, int rd, logic [31:0] pc, logic [31:0] ja, bit pr);
    vec_t v = N();
    v.iv = 1; v.ty = 2'(ty); v.rd = 5'(rd); v.pc = pc; v.ja = ja; v.pr = pr;
    return v;
  endfunction
  function automatic vec_t W(int id, logic [31:0] d, bit t);
    vec_t v = N();
    v.wv = 1; v.wid = 4'(id); v.wd = d; v.wt = t;
    return v;
  endfunction
  function automatic vec_t C(vec_t v, int rd, logic [31:0] d, int id);
    v.ec = 1; v.erd = 5'(rd); v.ed = d; v.eid = 4'(id);
    return v;
  endfunction
  function automatic vec_t S(vec_t v, int id);
    v.es = 1; v.esid = 4'(id);
    return v;
  endfunction
  function automatic vec_t R(vec_t v, logic [31:0] pc);
    v.eb = 1; v.epc = pc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int wid;
    // basic commit
    tbl.push_back(I(0, 5, 32'h0, 32'h0, 0));
    tbl.push_back(W(0, 32'h1234, 0));
    tbl.push_back(C(N(), 5, 32'h1234, 0));
    tbl.push_back(N());
    // out-of-order writeback, in-order commit
    tbl.push_back(I(0, 1, 32'h4, 0, 0));
    tbl.push_back(I(0, 2, 32'h8, 0, 0));
    tbl.push_back(I(0, 3, 32'hc, 0, 0));
    tbl.push_back(W(3, 32'h33, 0));
    tbl.push_back(W(2, 32'h22, 0));
    tbl.push_back(W(1, 32'h11, 0));
    tbl.push_back(C(N(), 1, 32'h11, 1));
    tbl.push_back(C(N(), 2, 32'h22, 2));
    tbl.push_back(C(N(), 3, 32'h33, 3));
    // store release and silent rd=0 retire
    tbl.push_back(I(2, 0, 32'h40, 0, 0));
    tbl.push_back(I(0, 0, 32'h44, 0, 0));
    tbl.push_back(W(4, 32'h0, 0));
    tbl.push_back(S(W(5, 32'h99, 0), 4));
    tbl.push_back(N());
    // taken mispredict with younger entries
    tbl.push_back(I(1, 0, 32'h100, 32'h200, 0));
    tbl.push_back(I(0, 7, 32'h104, 0, 0));
    tbl.push_back(I(0, 8, 32'h108, 0, 0));
    tbl.push_back(I(0, 9, 32'h10c, 0, 0));
    tbl.push_back(W(7, 32'h7, 0));
    tbl.push_back(W(6, 32'h0, 1));
    tbl.push_back(R(N(), 32'h200));
    tbl.push_back(W(7, 32'h5, 0));
    tbl.push_back(N());
    // not-taken mispredict, then correct prediction
    tbl.push_back(I(1, 0, 32'h300, 32'h400, 1));
    tbl.push_back(W(0, 32'h0, 0));
    tbl.push_back(R(N(), 32'h304));
    tbl.push_back(I(1, 0, 32'h500, 32'h600, 1));
    tbl.push_back(W(0, 32'h0, 1));
    tbl.push_back(N());

    do_reset();
    chk("rst_is_commit", is_commit, 0);
    chk("rst_store", store_commit, 0);
    chk("rst_rollback", rollback, 0);
    chk("rst_rollback_pc", rollback_pc, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_rob_full", rob_full, 0);
    chk("rst_issue_id", issue_rob_id, 0);

    foreach (tbl[k]) begin
      issue_valid = tbl[k].iv; issue_type = tbl[k].ty;
      issue_rd = tbl[k].rd; issue_pc = tbl[k].pc;
      issue_jump_addr = tbl[k].ja; issue_pred_taken = tbl[k].pr;
      wb_valid = tbl[k].wv; wb_rob_id = tbl[k].wid;
      wb_data = tbl[k].wd; wb_taken = tbl[k].wt;
      step();
      chk("tbl_commit", is_commit, tbl[k].ec);
      if (tbl[k].ec) begin
        chk("tbl_commit_rd", commit_rd, tbl[k].erd);
        chk("tbl_commit_data", commit_data, tbl[k].ed);
        chk("tbl_commit_id", commit_rob_id, tbl[k].eid);
      end
      chk("tbl_store", store_commit, tbl[k].es);
      if (tbl[k].es) chk("tbl_store_id", store_rob_id, tbl[k].esid);
      chk("tbl_rollback", rollback, tbl[k].eb);
      if (tbl[k].eb) chk("tbl_rollback_pc", rollback_pc, tbl[k].epc);
    end
    idle_in();

    // operand query before and after writeback (ids 1..3)
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_type = 0; issue_rd = 5'(10 + i);
      step();
    end
    idle_in();
    query_id1 = 3; query_id2 = 1;
    step();
    chk("q_before_ready", query_ready1, 0);
    chk("q_before_data", query_data1, 0);
    wb_valid = 1; wb_rob_id = 3; wb_data = 32'hABCD;
    step();
    chk("q_after_ready", query_ready1, 1);
    chk("q_after_data", query_data1, 32'hABCD);
    for (int i = 1; i <= 2; i++) begin
      wb_rob_id = 4'(i); wb_data = 32'(i);
      step();
    end
    idle_in();
    repeat (4) step();

    // reset while a commit is pending drops the pulse
    issue_valid = 1; issue_rd = 4;
    wid = m_tail;
    step();
    idle_in();
    wb_valid = 1; wb_rob_id = 4'(wid); wb_data = 32'h77;
    step();
    idle_in();
    do_reset();
    chk("rst_drop_commit", is_commit, 0);
    chk("rst_drop_id", issue_rob_id, 0);

    // fill, overflow attempt, wrap
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1; issue_type = 0; issue_rd = 5'(i + 1);
      step();
    end
    chk("full_set", rob_full, 1);
    issue_rd = 5'd31;
    step();
    chk("full_ignored_id", issue_rob_id, 0);
    idle_in();
    wb_valid = 1; wb_rob_id = 0; wb_data = 32'h5A;
    step();
    idle_in();
    step();
    chk("full_retire_commit", is_commit, 1);
    chk("full_retire_rd", commit_rd, 1);
    #1;
    chk("full_clear", rob_full, 0);
    chk("wrap_id", issue_rob_id, 0);
    issue_valid = 1; issue_rd = 5'd20;
    step();
    idle_in();
    for (int i = 1; i <= 16; i++) begin
      wb_valid = 1; wb_rob_id = 4'(i % 16); wb_data = 32'(i * 3);
      step();
    end
    idle_in();
    repeat (3) step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 99) < 55);
      issue_type = 2'($urandom_range(0, 2));
      issue_rd = 5'($urandom_range(0, 31));
      issue_pc = $urandom & 32'hFFFF_FFFC;
      issue_jump_addr = $urandom & 32'hFFFF_FFFC;
      issue_pred_taken = 1'($urandom_range(0, 1));
      wb_valid = ($urandom_range(0, 99) < 80);
      wb_data = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
        int ix = $urandom_range(0, mq.size() - 1);
        wb_rob_id = 4'(mq[ix].id);
        wb_taken = ($urandom_range(0, 99) < 80) ? mq[ix].pred : !mq[ix].pred;
      end else begin
        wb_rob_id = 4'($urandom_range(0, 15));
        wb_taken = 1'($urandom_range(0, 1));
      end
      query_id1 = 4'($urandom_range(0, 15));
      query_id2 = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between the decoder/issue stage and the architectural register file.
- Allocates one entry per issued instruction and collects results from the common data bus (CDB).
- Retires entries in program order: at most one register commit per cycle to the register file, plus store-release and branch-mispredict rollback signalling.
- Answers decoder operand queries by ROB id so operands that are already produced can be forwarded before commit.

Parameters:
- ROB_SZ, 16, number of entries; power of two. Entry index equals ROB id.
- ROB_ID_W, 4, log2(ROB_SZ); must match `ROB_ID_WID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- issue_valid  in  1  decoder allocates an entry this cycle.
- issue_type  in  2  0 = ALU/load (writes rd), 1 = branch, 2 = store.
- issue_rd  in  5  destination register.
- issue_pc  in  32  instruction PC.
- issue_jump_addr  in  32  branch target.
- issue_pred_taken  in  1  predictor decision.
- issue_rob_id  out  ROB_ID_W  id to be allocated (= tail).
- rob_full  out  1  no free entry.
- wb_valid  in  1  CDB result present.
- wb_rob_id  in  ROB_ID_W  CDB tag.
- wb_data  in  32  CDB result.
- wb_taken  in  1  actual branch outcome.
- query_id1, query_id2  in  ROB_ID_W  decoder operand tags.
- query_ready1, query_ready2  out  1  tagged entry has its result.
- query_data1, query_data2  out  32  tagged entry's result.
- is_commit  out  1  register commit pulse.
- commit_rd  out  5  committed destination.
- commit_data  out  32  committed value.
- commit_rob_id  out  ROB_ID_W  committed entry id.
- store_commit  out  1  head store may write memory.
- store_rob_id  out  ROB_ID_W  id of the released store.
- rollback  out  1  mispredict flush pulse.
- rollback_pc  out  32  redirect PC.

Behaviour:
- State: per-entry busy, ready, type, rd, data, pc, jump_addr, pred_taken, taken; head and tail pointers (ROB_ID_W wide, wrap naturally); count (ROB_ID_W+1 wide).
- Reset: all entries not busy; head = tail = count = 0. All registered outputs (is_commit, commit_*, store_*, rollback, rollback_pc) = 0.
- rob_full is combinational: count == ROB_SZ. issue_rob_id is combinational: tail.
- Issue: when issue_valid && !rob_full, write the entry at tail with busy = 1 and ready = 0, then tail++. issue_valid while full is ignored; no state change.
- Writeback: when wb_valid and entry[wb_rob_id].busy, set ready = 1 and capture data and taken. Writeback to a non-busy entry is ignored.
- Query outputs are combinational from registered entry state. No same-cycle CDB forwarding; ready = busy && ready. Data = 0 when not ready.
- Retirement (registered, 1-cycle latency): evaluate the head entry only when busy && ready && count > 0.
  - Type 0: pulse is_commit with commit_rd, commit_data and commit_rob_id = head. If rd == 0, the entry retires silently with no is_commit pulse.
  - Type 2: pulse store_commit with store_rob_id = head, then retire.
  - Type 1 with taken == pred_taken: retire, no output pulse.
  - Type 1 with taken != pred_taken: pulse rollback. rollback_pc = taken ? jump_addr : pc + 4.
- Head then advances by one. All pulses last exactly one cycle.
- Rollback flush: in the same edge, clear all busy bits and set head = tail = count = 0. Any issue or writeback arriving in that cycle is discarded.
- Count update: count += issue_accepted − retired. Simultaneous issue and retire leaves count unchanged. An issue while full is never accepted, even if a retire occurs in the same cycle.
- Pointer wrap-around: tail and head wrap from ROB_SZ−1 to 0 with no special handling.
- Reset during activity: all state is flushed at the next edge and any pending pulse is dropped.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- With the macro defined:
  - Add outputs perf_commit_cnt [31:0] and perf_rollback_cnt [31:0].
  - perf_commit_cnt increments on every retirement; perf_rollback_cnt increments on every rollback pulse.
  - Both are zeroed by reset and wrap at 2^32.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package / const.v:
  - `ROB_ID_WID, `REG_ID_WID, `DATA_WID, `ROB_SZ.
  - ROB type codes ROB_TYPE_REG = 0, ROB_TYPE_BR = 1, ROB_TYPE_ST = 2.
- Sub-module: a single natural one, rob_retire_logic. It is combinational head-entry evaluation producing retire/commit/store/rollback decisions and rollback_pc; the top module registers its results.

Test Plan:
- Reset, then issue rd = 5 → id 0; wb id 0 data 0x1234 → next edge is_commit = 1, commit_rd = 5, commit_data = 0x1234, commit_rob_id = 0; count returns to 0.
- Issue 16 entries → rob_full = 1; a 17th issue is ignored. Write back and retire head → rob_full = 0; a new issue gets id 0 (wrap).
- Writeback ids 2 then 1 then 0 out of order → commits occur in order 0, 1, 2 on consecutive cycles.
- Branch at pc 0x100 with pred_taken = 0 and wb_taken = 1, jump_addr 0x200, with 3 younger entries → rollback = 1, rollback_pc = 0x200; head = tail = count = 0; younger entries never commit.
- Store at head after wb → store_commit = 1, store_rob_id correct, no is_commit. An rd = 0 entry retires with no pulse.
- Query id 3 before and after its wb of 0xABCD → query_ready = 0 / data 0, then query_ready = 1 / data 0xABCD.
